tdc_readout_arbiter: RTL and testbench
======================================

// Module: tdc_readout_arbiter
// PURPOSE
// - Downstream consumer of N tdc_s3 instances. Drains their 32-bit FWFT FIFO ports
//   (FIFO_READ/FIFO_EMPTY/FIFO_DATA) round-robin into one FWFT output port feeding the SRAM FIFO.
// - Bounded bursts per source guarantee fairness. Words pass through unmodified,
//   since the top bits already carry each source's DATA_IDENTIFIER.
// PARAMETERS
// - N_SRC      2   number of upstream sources, 1..16
// - MAX_BURST  8   max words taken from one source per grant, >=1
// - DEPTH      4   output buffer entries, power of 2, >=2
// PORTS
// - BUS_CLK        in   1      sole clock
// - BUS_RST        in   1      synchronous, active-high reset
// - SRC_ENABLE     in   N_SRC  per-source enable mask
// - SRC_FIFO_EMPTY in   N_SRC  upstream FIFO_EMPTY, bit i = source i
// - SRC_FIFO_DATA  in   32*N   upstream FIFO_DATA, source i at [32*i+31:32*i]
// - SRC_FIFO_READ  out  N_SRC  pop strobe to upstream FIFO_READ
// - FIFO_READ      in   1      downstream pop
// - FIFO_EMPTY     out  1      output buffer empty
// - FIFO_DATA      out  32     head of output buffer (FWFT)
// - BUSY           out  1      state!=IDLE or buffer non-empty
// - WORD_CNT       out  32     total words forwarded, wraps
// BEHAVIOUR
// - Reset: state=IDLE; last_grant=N_SRC-1 (source 0 first); buffer empty.
//   Reset values: FIFO_EMPTY=1, FIFO_DATA=0, SRC_FIFO_READ=0, BUSY=0, WORD_CNT=0.
//   Reset mid-burst discards buffered words. No SRC_FIFO_READ is asserted in the reset cycle.
// - FSM IDLE: find the first i in last_grant+1 .. last_grant+N_SRC (mod N_SRC) with
//   SRC_ENABLE[i] & !SRC_FIFO_EMPTY[i]. If found: sel<=i, last_grant<=i, burst<=0, go to SERVE.
//   Otherwise stay in IDLE.
// - FSM SERVE: push = !SRC_FIFO_EMPTY[sel] & SRC_ENABLE[sel] & (count<DEPTH).
//   - SRC_FIFO_READ[sel] = push (combinational). All other bits are 0.
//   - On push, SRC_FIFO_DATA[sel] is written into the buffer in the same cycle.
//   - burst++ and WORD_CNT++ on each push.
//   - Return to IDLE on the cycle after: burst reaches MAX_BURST, the source goes empty,
//     or the source is disabled.
//   - Buffer full: stay in SERVE and hold burst. Full does not end the grant.
// - Each grant costs one IDLE bubble cycle. Sustained throughput is
//   MAX_BURST/(MAX_BURST+1) words/clk.
// - Output buffer:
//   - Push-when-full is impossible by construction.
//   - Pop while empty is ignored.
//   - Simultaneous push and pop leaves count unchanged and is allowed at count==DEPTH only
//     as a pop; the push gate uses the registered count.
//   - No bypass: a word pushed in cycle t is visible on FIFO_DATA at t+1. Latency is 1 clk.
// - FIFO_DATA is held stable while FIFO_EMPTY=0 and FIFO_READ=0.
// - Ordering: words from one source keep their order. Across sources, order follows grant order.
// - SRC_ENABLE dropping mid-burst ends the grant with no further pops. Words already taken stay.
// - N_SRC=1: the rotation degenerates and the bubble still applies.
// STRUCTURE
// - tdc_readout_defs.vh: DATA_W=32, state encodings ST_IDLE/ST_SERVE, clog2 function.
// - One sub-module, readout_fwft_fifo (DEPTH, 32-bit): ptrs, count, no bypass.
//   The arbiter FSM and the counters live in the top.
// TESTING
// - Reset, then src0 holds 3 words (A0..A2) and src1 is empty: exactly 3 READ[0] pulses.
//   Output A0,A1,A2. WORD_CNT=3. BUSY falls 2 clk after the last pop.
// - Both sources hold 20 words, MAX_BURST=8, downstream always reads:
//   output 8xsrc0, 8xsrc1, 8xsrc0, 8xsrc1, 4xsrc0, 4xsrc1.
//   One IDLE cycle between bursts.
// - FIFO_READ held 0 with src0 holding 10 words: exactly DEPTH=4 pops, FSM stalls in SERVE.
//   Release FIFO_READ: remaining 6 words follow in order with no loss or duplication.
// - SRC_ENABLE[1]=0 with src1 non-empty: READ[1] never asserts.
//   Set it to 1 mid-run: src1 is served on the next IDLE after the current burst.
// - BUS_RST pulsed during a burst with buffer count=3: FIFO_EMPTY=1 the next clk,
//   WORD_CNT=0, next grant goes to src0.
// - Downstream FIFO_READ asserted while FIFO_EMPTY=1: no state change and no underflow.

Source files
------------

// File: rtl/tdc_readout_arbiter_pkg.sv
// Shared types and constants for the TDC readout arbiter slice.
package tdc_readout_arbiter_pkg;

  localparam int DATA_W = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } arb_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/tdc_readout_arbiter_if.sv
// Source-side FWFT ports of N TDCs plus the merged FWFT output port.
interface tdc_readout_arbiter_if
  import tdc_readout_arbiter_pkg::*;
#(
  parameter int N_SRC = 2
);
  logic [N_SRC-1:0]        SRC_ENABLE;
  logic [N_SRC-1:0]        SRC_FIFO_EMPTY;
  logic [DATA_W*N_SRC-1:0] SRC_FIFO_DATA;
  logic [N_SRC-1:0]        SRC_FIFO_READ;
  logic                    FIFO_READ;
  logic                    FIFO_EMPTY;
  logic [DATA_W-1:0]       FIFO_DATA;
  logic                    BUSY;
  logic [31:0]             WORD_CNT;

  modport slave (
    input  SRC_ENABLE, SRC_FIFO_EMPTY, SRC_FIFO_DATA, FIFO_READ,
    output SRC_FIFO_READ, FIFO_EMPTY, FIFO_DATA, BUSY, WORD_CNT
  );

  modport master (
    output SRC_ENABLE, SRC_FIFO_EMPTY, SRC_FIFO_DATA, FIFO_READ,
    input  SRC_FIFO_READ, FIFO_EMPTY, FIFO_DATA, BUSY, WORD_CNT
  );
endinterface

// File: rtl/tdc_readout_arbiter_fwft_fifo.sv
// Small first-word-fall-through output buffer; a pushed word shows on head one clock later.
module readout_fwft_fifo
  import tdc_readout_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DATA_W,
  parameter int PTR_W = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] head,
  output logic [PTR_W:0]   count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_ok;

  assign empty  = (count == '0);
  assign pop_ok = pop & ~empty;
  // Head is forced to zero while empty so the port reads 0 out of reset.
  assign head   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tdc_readout_arbiter.sv
// Round-robin drain of N TDC FWFT FIFOs into one FWFT port, bounded bursts per grant.
//   state    | meaning
//   ST_IDLE  | bubble cycle: pick next enabled non-empty source after last_grant
//   ST_SERVE | pop granted source into buffer until burst limit, empty or disable
module tdc_readout_arbiter
  import tdc_readout_arbiter_pkg::*;
#(
  parameter int N_SRC     = 2,
  parameter int MAX_BURST = 8,
  parameter int DEPTH     = 4
) (
  input logic                  BUS_CLK,
  input logic                  BUS_RST,
  tdc_readout_arbiter_if.slave bus
);

  localparam int SEL_W   = (N_SRC > 1) ? clog2(N_SRC) : 1;
  localparam int BURST_W = clog2(MAX_BURST + 1);
  localparam int PTR_W   = clog2(DEPTH);
  localparam logic [PTR_W:0]     DEPTH_C = (PTR_W + 1)'(DEPTH);
  localparam logic [BURST_W-1:0] BURST_C = BURST_W'(MAX_BURST);

  arb_state_t         state, state_nxt;
  logic [SEL_W-1:0]   sel, sel_nxt;
  logic [SEL_W-1:0]   last_grant, last_grant_nxt;
  logic [BURST_W-1:0] burst_left, burst_left_nxt;
  logic [SEL_W-1:0]   found_idx;
  logic               found;
  logic               push;
  logic [DATA_W-1:0]  sel_data;
  logic [PTR_W:0]     fifo_count;
  logic               fifo_empty;

  assign sel_data = bus.SRC_FIFO_DATA[DATA_W*sel +: DATA_W];
  // Push gate uses the registered count, so a same-cycle pop never frees a slot early.
  assign push = (state == ST_SERVE) & ~BUS_RST & bus.SRC_ENABLE[sel]
              & ~bus.SRC_FIFO_EMPTY[sel] & (fifo_count < DEPTH_C);

  always_comb begin
    int idx;
    logic [SEL_W-1:0] cand;
    found     = 1'b0;
    found_idx = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      cand = SEL_W'(idx);
      if (!found && bus.SRC_ENABLE[cand] && !bus.SRC_FIFO_EMPTY[cand]) begin
        found     = 1'b1;
        found_idx = cand;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    sel_nxt        = sel;
    last_grant_nxt = last_grant;
    burst_left_nxt = burst_left;
    case (state)
      ST_IDLE: begin
        if (found) begin
          state_nxt      = ST_SERVE;
          sel_nxt        = found_idx;
          last_grant_nxt = found_idx;
          burst_left_nxt = BURST_C;
        end
      end
      ST_SERVE: begin
        if (!bus.SRC_ENABLE[sel] || bus.SRC_FIFO_EMPTY[sel]) begin
          state_nxt = ST_IDLE;
        end else if (push) begin
          burst_left_nxt = burst_left - 1'b1;
          if (burst_left == BURST_W'(1)) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.SRC_FIFO_READ      = '0;
    bus.SRC_FIFO_READ[sel] = push;
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state        <= ST_IDLE;
      sel          <= '0;
      last_grant   <= SEL_W'(N_SRC - 1);
      burst_left   <= '0;
      bus.WORD_CNT <= '0;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      last_grant <= last_grant_nxt;
      burst_left <= burst_left_nxt;
      if (push) bus.WORD_CNT <= bus.WORD_CNT + 32'd1;
    end
  end

  readout_fwft_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk       (BUS_CLK),
    .rst       (BUS_RST),
    .push      (push),
    .push_data (sel_data),
    .pop       (bus.FIFO_READ),
    .empty     (fifo_empty),
    .head      (bus.FIFO_DATA),
    .count     (fifo_count)
  );

  assign bus.FIFO_EMPTY = fifo_empty;
  assign bus.BUSY       = (state != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_tdc_readout_arbiter.sv
// Directed bench for tdc_readout_arbiter: two modelled upstream FIFOs and a scoreboard of output words.
module tb_tdc_readout_arbiter;

  localparam int N = 2;

  logic clk;
  logic rst;

  tdc_readout_arbiter_if #(.N_SRC(N)) ifc ();

  tdc_readout_arbiter #(
    .N_SRC     (N),
    .MAX_BURST (8),
    .DEPTH     (4)
  ) dut (
    .BUS_CLK (clk),
    .BUS_RST (rst),
    .bus     (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] src_q [N][$];
  logic [31:0] out_q [$];
  logic [31:0] exp_q [$];
  int          rd_cnt [N];
  int          cycle;
  int          last_pop_cycle;
  int          first_pop_cycle;
  int          busy_fall_cycle;
  logic        busy_s;
  logic        busy_prev;
  logic [N-1:0] last_rd;
  int          n_checks;
  int          n_fail;

  function automatic logic [31:0] w(input int s, input int t, input int j);
    return (32'(s) << 28) | (32'(t) << 16) | 32'(j);
  endfunction

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_src();
    for (int i = 0; i < N; i++) begin
      ifc.SRC_FIFO_EMPTY[i] = (src_q[i].size() == 0);
      ifc.SRC_FIFO_DATA[32*i +: 32] = (src_q[i].size() != 0) ? src_q[i][0] : 32'h0;
    end
  endtask

  task automatic step();
    logic [N-1:0] rd;
    logic         pop;
    logic [31:0]  head;
    @(negedge clk);
    rd      = ifc.SRC_FIFO_READ;
    pop     = ifc.FIFO_READ && !ifc.FIFO_EMPTY;
    head    = ifc.FIFO_DATA;
    busy_s  = ifc.BUSY;
    last_rd = rd;
    if (!busy_s && busy_prev && busy_fall_cycle < 0) busy_fall_cycle = cycle;
    busy_prev = busy_s;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rd[i]) begin
        rd_cnt[i]++;
        last_pop_cycle = cycle;
        if (first_pop_cycle < 0) first_pop_cycle = cycle;
        if (src_q[i].size() > 0) void'(src_q[i].pop_front());
      end
    end
    if (pop) out_q.push_back(head);
    cycle++;
    drive_src();
  endtask

  task automatic run_until_idle(input string tag, input int bound);
    int  n;
    logic done;
    n    = 0;
    done = 1'b0;
    while (!done && n < bound) begin
      step();
      n++;
      done = (src_q[0].size() == 0) && (src_q[1].size() == 0) && !busy_s;
    end
    chk_eq({tag, "_timeout"}, {31'b0, !done}, 32'd0);
  endtask

  task automatic clear_tb();
    out_q.delete();
    exp_q.delete();
    for (int i = 0; i < N; i++) rd_cnt[i] = 0;
    first_pop_cycle = -1;
    last_pop_cycle  = -1;
    busy_fall_cycle = -1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic cmp_out(input string tag);
    chk_eq({tag, "_len"}, 32'(out_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < out_q.size()) chk_eq($sformatf("%s_w%0d", tag, k), out_q[k], exp_q[k]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    cycle     = 0;
    busy_prev = 1'b0;
    busy_s    = 1'b0;
    rst       = 1'b1;
    ifc.SRC_ENABLE = 2'b11;
    ifc.FIFO_READ  = 1'b0;
    clear_tb();
    drive_src();
    repeat (3) step();
    rst = 1'b0;
    step();

    chk_eq("rst_empty",    {31'b0, ifc.FIFO_EMPTY}, 32'd1);
    chk_eq("rst_data",     ifc.FIFO_DATA, 32'd0);
    chk_eq("rst_src_read", {30'b0, ifc.SRC_FIFO_READ}, 32'd0);
    chk_eq("rst_busy",     {31'b0, ifc.BUSY}, 32'd0);
    chk_eq("rst_word_cnt", ifc.WORD_CNT, 32'd0);

    // Three words on src0, src1 empty.
    clear_tb();
    for (int j = 0; j < 3; j++) src_q[0].push_back(w(0, 1, j));
    ifc.FIFO_READ = 1'b1;
    drive_src();
    run_until_idle("t1", 60);
    chk_eq("t1_rd0", 32'(rd_cnt[0]), 32'd3);
    chk_eq("t1_rd1", 32'(rd_cnt[1]), 32'd0);
    for (int j = 0; j < 3; j++) exp_q.push_back(w(0, 1, j));
    cmp_out("t1");
    chk_eq("t1_word_cnt", ifc.WORD_CNT, 32'd3);
    chk_eq("t1_busy_fall", 32'(busy_fall_cycle - last_pop_cycle), 32'd2);

    // Both sources hold 20 words, downstream always reads.
    do_reset();
    clear_tb();
    for (int j = 0; j < 20; j++) begin
      src_q[0].push_back(w(0, 2, j));
      src_q[1].push_back(w(1, 2, j));
    end
    drive_src();
    run_until_idle("t2", 200);
    for (int b = 0; b < 3; b++) begin
      for (int s = 0; s < 2; s++) begin
        for (int j = 8*b; j < ((b == 2) ? 20 : 8*b + 8); j++) exp_q.push_back(w(s, 2, j));
      end
    end
    cmp_out("t2");
    chk_eq("t2_word_cnt", ifc.WORD_CNT, 32'd40);
    chk_eq("t2_span", 32'(last_pop_cycle - first_pop_cycle), 32'd45);

    // Downstream stalled: buffer fills and the grant holds.
    do_reset();
    clear_tb();
    ifc.FIFO_READ = 1'b0;
    for (int j = 0; j < 10; j++) src_q[0].push_back(w(0, 3, j));
    drive_src();
    repeat (12) step();
    chk_eq("t3_stall_rd0",  32'(rd_cnt[0]), 32'd4);
    chk_eq("t3_stall_empty", {31'b0, ifc.FIFO_EMPTY}, 32'd0);
    chk_eq("t3_stall_head", ifc.FIFO_DATA, w(0, 3, 0));
    chk_eq("t3_stall_busy", {31'b0, ifc.BUSY}, 32'd1);
    ifc.FIFO_READ = 1'b1;
    run_until_idle("t3", 100);
    chk_eq("t3_rd0", 32'(rd_cnt[0]), 32'd10);
    for (int j = 0; j < 10; j++) exp_q.push_back(w(0, 3, j));
    cmp_out("t3");
    chk_eq("t3_word_cnt", ifc.WORD_CNT, 32'd10);

    // src1 disabled while non-empty, enabled mid-burst of src0.
    do_reset();
    clear_tb();
    ifc.SRC_ENABLE = 2'b01;
    for (int j = 0; j < 12; j++) src_q[0].push_back(w(0, 4, j));
    for (int j = 0; j < 5; j++)  src_q[1].push_back(w(1, 4, j));
    drive_src();
    repeat (5) step();
    chk_eq("t4_dis_rd1", 32'(rd_cnt[1]), 32'd0);
    chk_eq("t4_dis_rd0", 32'(rd_cnt[0]), 32'd4);
    ifc.SRC_ENABLE = 2'b11;
    run_until_idle("t4", 100);
    for (int j = 0; j < 8; j++)  exp_q.push_back(w(0, 4, j));
    for (int j = 0; j < 5; j++)  exp_q.push_back(w(1, 4, j));
    for (int j = 8; j < 12; j++) exp_q.push_back(w(0, 4, j));
    cmp_out("t4");
    chk_eq("t4_word_cnt", ifc.WORD_CNT, 32'd17);

    // Reset pulsed mid-burst with three words buffered.
    do_reset();
    clear_tb();
    ifc.FIFO_READ = 1'b0;
    for (int j = 0; j < 10; j++) begin
      src_q[0].push_back(w(0, 5, j));
      src_q[1].push_back(w(1, 5, j));
    end
    drive_src();
    repeat (4) step();
    chk_eq("t5_pre_word_cnt", ifc.WORD_CNT, 32'd3);
    chk_eq("t5_pre_rd0", 32'(rd_cnt[0]), 32'd3);
    chk_eq("t5_pre_empty", {31'b0, ifc.FIFO_EMPTY}, 32'd0);
    rst = 1'b1;
    step();
    chk_eq("t5_rst_cycle_read", {30'b0, last_rd}, 32'd0);
    rst = 1'b0;
    chk_eq("t5_post_empty", {31'b0, ifc.FIFO_EMPTY}, 32'd1);
    chk_eq("t5_post_word_cnt", ifc.WORD_CNT, 32'd0);
    chk_eq("t5_post_data", ifc.FIFO_DATA, 32'd0);
    chk_eq("t5_post_busy", {31'b0, ifc.BUSY}, 32'd0);
    ifc.FIFO_READ = 1'b1;
    run_until_idle("t5", 100);
    if (out_q.size() > 0) chk_eq("t5_first", out_q[0], w(0, 5, 3));
    for (int j = 3; j < 10; j++) exp_q.push_back(w(0, 5, j));
    for (int j = 0; j < 10; j++) exp_q.push_back(w(1, 5, j));
    cmp_out("t5");

    // Downstream reads while empty, then one more word flows normally.
    clear_tb();
    repeat (5) step();
    chk_eq("t6_empty", {31'b0, ifc.FIFO_EMPTY}, 32'd1);
    chk_eq("t6_busy", {31'b0, ifc.BUSY}, 32'd0);
    chk_eq("t6_word_cnt", ifc.WORD_CNT, 32'd17);
    chk_eq("t6_no_out", 32'(out_q.size()), 32'd0);
    src_q[1].push_back(w(1, 6, 0));
    drive_src();
    run_until_idle("t6", 40);
    exp_q.push_back(w(1, 6, 0));
    cmp_out("t6");
    chk_eq("t6_word_cnt_after", ifc.WORD_CNT, 32'd18);
    chk_eq("t6_empty_after", {31'b0, ifc.FIFO_EMPTY}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
